// File: rtl/whack_pkg.sv
// whack_pkg: shared state encoding, LFSR constants and step function for the mole spawner
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_PICK,
        ST_SHOW,
        ST_DONE
    } state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam int          NPOS_DEFAULT = 10;

    // One step of a right-shifting Galois LFSR: the bit shifted out selects the tap XOR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/mole_spawner_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, reloads SEED on reset
module lfsr16
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    logic [15:0] q_q;

    // Advance every cycle out of reset, independent of the game state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_q <= SEED;
        else          q_q <= lfsr_step(q_q);
    end

    assign q = q_q;

endmodule

// File: rtl/mole_spawner.sv
// mole_spawner: picks random non-repeating mole positions, times show/gap windows, counts turns
module mole_spawner
    import whack_pkg::*;
#(
    parameter int          NPOS        = NPOS_DEFAULT,
    parameter int          HOLD_CYCLES = 25_000_000,
    parameter int          GAP_CYCLES  = 12_500_000,
    parameter int          TURNS       = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         hit,
    output logic [NPOS-1:0]              location,
    output logic                         mole_valid,
    output logic                         miss,
    output logic [$clog2(TURNS+1)-1:0]   turn,
    output logic                         done
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int TW   = $clog2(TURNS + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [4:0]    POS_NONE  = 5'(NPOS);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNS);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NPOS-1:0] loc_q, loc_d;
    logic          valid_q, valid_d;
    logic          miss_q, miss_d;
    logic          done_q, done_d;
    logic [TW-1:0] turn_q, turn_d;
    logic [4:0]    prev_q, prev_d;

    logic [15:0]   lfsr;
    logic          lfsr_unused;
    logic [4:0]    idx;
    logic          idx_ok;
    logic          cnt_zero;
    logic [TW-1:0] turn_inc;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr)
    );

    // Only the low nibble picks a position; the upper bits just keep the sequence long.
    assign lfsr_unused = ^lfsr[15:4];
    assign idx         = {1'b0, lfsr[3:0]};
    assign idx_ok      = (idx < POS_NONE) && (idx != prev_q);
    assign cnt_zero    = (cnt_q == '0);
    assign turn_inc    = turn_q + 1'b1;

    // State and output registers; reset clears everything so no miss can leak out of a SHOW.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            loc_q   <= '0;
            valid_q <= 1'b0;
            miss_q  <= 1'b0;
            done_q  <= 1'b0;
            turn_q  <= '0;
            prev_q  <= POS_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loc_q   <= loc_d;
            valid_q <= valid_d;
            miss_q  <= miss_d;
            done_q  <= done_d;
            turn_q  <= turn_d;
            prev_q  <= prev_d;
        end
    end

    // Next-state logic: GAP counts down, PICK retries until a fresh legal position, SHOW ends on hit or timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loc_d   = loc_q;
        valid_d = valid_q;
        miss_d  = 1'b0;
        done_d  = done_q;
        turn_d  = turn_q;
        prev_d  = prev_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    turn_d  = '0;
                    done_d  = 1'b0;
                end
            end
            ST_GAP: begin
                if (cnt_zero) state_d = ST_PICK;
                else          cnt_d   = cnt_q - 1'b1;
            end
            ST_PICK: begin
                if (idx_ok) begin
                    state_d = ST_SHOW;
                    loc_d   = NPOS'(1) << idx[3:0];
                    valid_d = 1'b1;
                    prev_d  = idx;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_SHOW: begin
                cnt_d = cnt_q - 1'b1;
                if (hit || cnt_zero) begin
                    miss_d  = !hit;
                    loc_d   = '0;
                    valid_d = 1'b0;
                    turn_d  = turn_inc;
                    cnt_d   = GAP_LOAD;
                    done_d  = (turn_inc == TURN_LAST);
                    state_d = (turn_inc == TURN_LAST) ? ST_DONE : ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign location   = loc_q;
    assign mole_valid = valid_q;
    assign miss       = miss_q;
    assign turn       = turn_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: directed checks of mole timing, hits, races, full game and reset robustness
module tb_mole_spawner;

    localparam int          NPOS  = 10;
    localparam int          HOLD  = 8;
    localparam int          GAP   = 3;
    localparam int          TURNS = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic            clk, reset_n, start, hit;
    logic [NPOS-1:0] location;
    logic            mole_valid, miss, done;
    logic [2:0]      turn;

    logic [15:0]     m_lfsr;
    logic [NPOS-1:0] prev_loc = '0;
    int              checks   = 0;
    int              errors   = 0;
    int              prev     = NPOS;
    int              exp_turn = 0;

    mole_spawner #(
        .NPOS        (NPOS),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .TURNS       (TURNS),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .hit        (hit),
        .location   (location),
        .mole_valid (mole_valid),
        .miss       (miss),
        .turn       (turn),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [15:0] step(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Reference LFSR running alongside the DUT from the same reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= SEED;
        else          m_lfsr <= step(m_lfsr);
    end

    function automatic logic [31:0] outs();
        return {16'd0, mole_valid, location, miss, turn, done};
    endfunction

    function automatic logic [31:0] pk(input logic v, input logic [NPOS-1:0] l, input logic m,
                                       input int t, input logic d);
        return {16'd0, v, l, m, 3'(t), d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_turn = 0;
        chk("start", outs(), pk(0, '0, 0, 0, 0));
    endtask

    // Entered on the first sample of a GAP; runs one mole and returns on the first sample after it ends.
    task automatic mole(input int hit_k, input int start_k, input int rst_k, input bit gap_hit);
        logic [15:0]     v;
        logic [NPOS-1:0] exp_loc;
        int              n, idx;
        v = m_lfsr;
        for (int i = 0; i < GAP; i++) v = step(v);
        n = 0;
        while (!(v[3:0] < 4'(NPOS) && int'(v[3:0]) != prev) && n < 1000) begin
            v = step(v);
            n++;
        end
        idx = int'(v[3:0]);
        exp_loc = '0;
        exp_loc[idx] = 1'b1;
        hit = gap_hit;
        for (int s = 1; s <= GAP + n; s++) begin
            @(negedge clk);
            hit = 1'b0;
            chk("dark", outs(), pk(0, '0, 0, exp_turn, 0));
        end
        @(negedge clk);
        chk("rise", outs(), pk(1, exp_loc, 0, exp_turn, 0));
        chk("onehot", {31'd0, $onehot(location)}, 32'd1);
        chk("new_pos", {31'd0, location == prev_loc}, 32'd0);
        prev = idx;
        prev_loc = exp_loc;
        for (int k = 1; k <= HOLD; k++) begin
            chk("show", outs(), pk(1, exp_loc, 0, exp_turn, 0));
            if (k == rst_k) begin
                reset_n = 1'b0;
                #1;
                chk("async_rst", outs(), pk(0, '0, 0, 0, 0));
                exp_turn = 0;
                prev = NPOS;
                prev_loc = '0;
                @(negedge clk);
                chk("rst_hold", outs(), pk(0, '0, 0, 0, 0));
                reset_n = 1'b1;
                return;
            end
            start = (k == start_k);
            hit = (k == hit_k);
            @(negedge clk);
            start = 1'b0;
            hit = 1'b0;
            if (k == hit_k || k == HOLD) begin
                exp_turn++;
                chk(k == hit_k ? "end_hit" : "end_miss", outs(),
                    pk(0, '0, k != hit_k, exp_turn, exp_turn == TURNS));
                return;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        hit = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", outs(), pk(0, '0, 0, 0, 0));
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle", outs(), pk(0, '0, 0, 0, 0));
        end
        start_game();
        mole(0, 0, 0, 1'b0);
        mole(3, 0, 0, 1'b0);
        mole(HOLD, 0, 0, 1'b0);
        mole(0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_hold", outs(), pk(0, '0, 0, TURNS, 1));
        end
        start_game();
        mole(0, 4, 0, 1'b1);
        mole(0, 0, 3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_idle", outs(), pk(0, '0, 0, 0, 0));
        end
        start_game();
        mole(2, 0, 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
